// File: rtl/io_tx_word_serializer_if.sv
// Upstream/downstream handshake bundle for the TX word serializer.
// The serializer connects through the slave modport; the feeding/draining side uses master.
interface io_tx_word_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  sof_i;
  logic                  eof_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [OUT_WIDTH-1:0]  data_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  data_i, sof_i, eof_i, valid_i, ready_i,
    output ready_o, data_o, sof_o, eof_o, valid_o
  );

  modport master (
    output data_i, sof_i, eof_i, valid_i, ready_i,
    input  ready_o, data_o, sof_o, eof_o, valid_o
  );
endinterface

// File: rtl/io_tx_word_serializer.sv
// Breaks upstream words into 1/2/4 output bytes, LSB- or MSB-first, with byte-level
// frame marks, zero-bubble word chaining and a saturating handed-off byte counter.
module io_tx_word_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic [1:0]                  cfg_size_i,
  input  logic                        cfg_msb_first_i,
  io_tx_word_serializer_if.slave      bus,
  output logic                        busy_o,
  output logic [15:0]                 tx_bytes_o
);
  localparam int BYTES = DATA_WIDTH / OUT_WIDTH;
  localparam int IW    = $clog2(BYTES);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [2:0]            r_remain;
  logic                  r_eof;
  logic [2:0]            size_dec;
  logic                  acc, hs;

  always_comb begin
    size_dec = 3'd4;
    case (cfg_size_i)
      2'b00:   size_dec = 3'd1;
      2'b01:   size_dec = 3'd2;
      default: size_dec = 3'd4;
    endcase
  end

  // Words are stored in emission order so the output byte is always the low lane.
  function automatic logic [DATA_WIDTH-1:0] order_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [2:0] sz,
                                                         input logic msb);
    logic [DATA_WIDTH-1:0] r;
    logic [IW-1:0]         src;
    r = d;
    if (msb) begin
      r = '0;
      for (int k = 0; k < BYTES; k++) begin
        src = IW'(sz - 3'd1 - 3'(k));
        if (k < int'(sz)) r[k*OUT_WIDTH +: OUT_WIDTH] = d[src*OUT_WIDTH +: OUT_WIDTH];
      end
    end
    return r;
  endfunction

  assign bus.ready_o = !rst_i && !clr_i &&
                       (state == IDLE || (r_remain == 3'd1 && bus.ready_i));
  assign acc         = bus.valid_i && bus.ready_o;
  assign hs          = bus.valid_o && bus.ready_i;
  assign bus.data_o  = r_word[OUT_WIDTH-1:0];
  assign busy_o      = bus.valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state       <= IDLE;
      bus.valid_o <= 1'b0;
      bus.sof_o   <= 1'b0;
      bus.eof_o   <= 1'b0;
      r_word      <= '0;
      r_remain    <= 3'd0;
      r_eof       <= 1'b0;
      tx_bytes_o  <= 16'd0;
    end else begin
      if (hs && tx_bytes_o != 16'hFFFF) tx_bytes_o <= tx_bytes_o + 16'd1;
      if (acc) begin
        state       <= SHIFT;
        bus.valid_o <= 1'b1;
        r_word      <= order_bytes(bus.data_i, size_dec, cfg_msb_first_i);
        r_remain    <= size_dec;
        r_eof       <= bus.eof_i;
        bus.sof_o   <= bus.sof_i;
        bus.eof_o   <= bus.eof_i && size_dec == 3'd1;
      end else if (hs) begin
        r_word    <= r_word >> OUT_WIDTH;
        r_remain  <= r_remain - 3'd1;
        bus.sof_o <= 1'b0;
        bus.eof_o <= r_eof && r_remain == 3'd2;
        if (r_remain == 3'd1) begin
          state       <= IDLE;
          bus.valid_o <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_io_tx_word_serializer.sv
// Directed-vector bench for io_tx_word_serializer with hand-computed expectations.
module tb_io_tx_word_serializer;
  logic        clk = 1'b0;
  logic        rst_i, clr_i, cfg_msb_first_i;
  logic [1:0]  cfg_size_i;
  logic        busy_o;
  logic [15:0] tx_bytes_o;
  int          nvec = 0;
  int          nerr = 0;

  io_tx_word_serializer_if #(.DATA_WIDTH(32), .OUT_WIDTH(8)) bus();

  io_tx_word_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .cfg_size_i     (cfg_size_i),
    .cfg_msb_first_i(cfg_msb_first_i),
    .bus            (bus),
    .busy_o         (busy_o),
    .tx_bytes_o     (tx_bytes_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [31:0] d, input logic s, input logic e);
    bus.data_i  = d;
    bus.sof_i   = s;
    bus.eof_i   = e;
    bus.valid_i = 1'b1;
  endtask

  initial begin
    logic [7:0] eb [4];
    rst_i = 1'b1; clr_i = 1'b0; cfg_size_i = 2'b10; cfg_msb_first_i = 1'b0;
    bus.data_i = '0; bus.sof_i = 1'b0; bus.eof_i = 1'b0; bus.valid_i = 1'b0; bus.ready_i = 1'b0;

    // reset
    tick(); tick();
    chk("rst_ready", 32'(bus.ready_o), 0);
    chk("rst_valid", 32'(bus.valid_o), 0);
    rst_i = 1'b0; #1;
    chk("post_rst_ready", 32'(bus.ready_o), 1);
    chk("post_rst_data", 32'(bus.data_o), 0);
    chk("post_rst_marks", {30'd0, bus.sof_o, bus.eof_o}, 0);
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_tx", 32'(tx_bytes_o), 0);

    // size 4 LSB-first, sof+eof
    eb = '{8'h11, 8'h22, 8'h33, 8'h44};
    cfg_size_i = 2'b10; cfg_msb_first_i = 1'b0; bus.ready_i = 1'b1;
    word(32'h44332211, 1'b1, 1'b1);
    tick();
    bus.valid_i = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      chk("w4_valid", 32'(bus.valid_o), 1);
      chk("w4_data", 32'(bus.data_o), 32'(eb[i]));
      chk("w4_sof", 32'(bus.sof_o), (i == 0) ? 1 : 0);
      chk("w4_eof", 32'(bus.eof_o), (i == 3) ? 1 : 0);
      tick();
    end
    chk("w4_idle", 32'(bus.valid_o), 0);
    chk("w4_tx", 32'(tx_bytes_o), 4);

    // size 2 MSB-first, two words back to back
    cfg_size_i = 2'b01; cfg_msb_first_i = 1'b1;
    word(32'hAABB1234, 1'b1, 1'b0); #1;
    chk("b2b_ready_idle", 32'(bus.ready_o), 1);
    tick();
    word(32'hCCDD5678, 1'b0, 1'b1); #1;
    chk("b2b_d0", 32'(bus.data_o), 32'h12);
    chk("b2b_sof0", 32'(bus.sof_o), 1);
    chk("b2b_rdy0", 32'(bus.ready_o), 0);
    tick();
    chk("b2b_d1", 32'(bus.data_o), 32'h34);
    chk("b2b_rdy1", 32'(bus.ready_o), 1);
    tick();
    bus.valid_i = 1'b0; #1;
    chk("b2b_d2", 32'(bus.data_o), 32'h56);
    chk("b2b_v2", 32'(bus.valid_o), 1);
    chk("b2b_rdy2", 32'(bus.ready_o), 0);
    tick();
    chk("b2b_d3", 32'(bus.data_o), 32'h78);
    chk("b2b_eof3", 32'(bus.eof_o), 1);
    chk("b2b_rdy3", 32'(bus.ready_o), 1);
    tick();
    chk("b2b_idle", 32'(bus.valid_o), 0);
    chk("b2b_tx", 32'(tx_bytes_o), 8);

    // downstream stall on byte 1
    cfg_size_i = 2'b10; cfg_msb_first_i = 1'b0;
    word(32'h87654321, 1'b0, 1'b0);
    tick();
    bus.valid_i = 1'b0;
    tick();
    bus.ready_i = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_data", 32'(bus.data_o), 32'h43);
      chk("stall_ready", 32'(bus.ready_o), 0);
      chk("stall_tx", 32'(tx_bytes_o), 9);
      tick();
    end
    bus.ready_i = 1'b1; #1;
    chk("stall_hold", 32'(bus.data_o), 32'h43);
    tick();
    chk("stall_b2", 32'(bus.data_o), 32'h65);
    tick(); tick();
    chk("stall_idle", 32'(bus.valid_o), 0);
    chk("stall_tx_end", 32'(tx_bytes_o), 12);

    // size changed mid-word
    eb = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    cfg_size_i = 2'b10;
    word(32'h0D0C0B0A, 1'b0, 1'b0);
    tick();
    bus.valid_i = 1'b0; cfg_size_i = 2'b00; #1;
    for (int i = 0; i < 4; i++) begin
      chk("cfgchg_data", 32'(bus.data_o), 32'(eb[i]));
      tick();
    end
    chk("cfgchg_idle", 32'(bus.valid_o), 0);
    word(32'h112233EE, 1'b1, 1'b1);
    tick();
    bus.valid_i = 1'b0; #1;
    chk("sz1_data", 32'(bus.data_o), 32'hEE);
    chk("sz1_marks", {30'd0, bus.sof_o, bus.eof_o}, 3);
    tick();
    chk("sz1_idle", 32'(bus.valid_o), 0);
    chk("sz1_tx", 32'(tx_bytes_o), 17);

    // clr after two of four bytes
    cfg_size_i = 2'b10;
    word(32'h44332211, 1'b0, 1'b0);
    tick();
    bus.valid_i = 1'b0;
    tick(); tick();
    chk("clr_pre_data", 32'(bus.data_o), 32'h33);
    clr_i = 1'b1;
    word(32'h99887766, 1'b0, 1'b0); #1;
    chk("clr_ready", 32'(bus.ready_o), 0);
    tick();
    clr_i = 1'b0; #1;
    chk("clr_valid", 32'(bus.valid_o), 0);
    chk("clr_tx", 32'(tx_bytes_o), 0);
    chk("clr_ready_after", 32'(bus.ready_o), 1);
    tick();
    bus.valid_i = 1'b0; #1;
    chk("clr_next_b0", 32'(bus.data_o), 32'h66);
    repeat (4) tick();
    chk("clr_next_tx", 32'(tx_bytes_o), 4);

    // counter saturation with 65540 single-byte words
    clr_i = 1'b1; tick(); clr_i = 1'b0;
    cfg_size_i = 2'b00;
    word(32'h0000005A, 1'b0, 1'b0);
    repeat (65535) tick();
    chk("sat_fffe", 32'(tx_bytes_o), 32'hFFFE);
    repeat (5) tick();
    chk("sat_ffff", 32'(tx_bytes_o), 32'hFFFF);
    bus.valid_i = 1'b0;
    tick();
    chk("sat_hold", 32'(tx_bytes_o), 32'hFFFF);
    chk("sat_idle", 32'(bus.valid_o), 0);

    // reset mid-word drops it
    cfg_size_i = 2'b10;
    word(32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    bus.valid_i = 1'b0;
    tick();
    rst_i = 1'b1; #1;
    chk("midrst_ready", 32'(bus.ready_o), 0);
    tick();
    chk("midrst_valid", 32'(bus.valid_o), 0);
    chk("midrst_tx", 32'(tx_bytes_o), 0);
    rst_i = 1'b0;
    tick();
    chk("midrst_after", {23'd0, bus.valid_o, bus.data_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/io_tx_word_serializer.md
IO_TX_WORD_SERIALIZER -- requirements
Module: io_tx_word_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input word width; fixed at 32 in this release.
REQ-002 SHALL have parameter OUT_WIDTH, default 8, output beat width; fixed at 8.
REQ-003 SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1, clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clr_i, input, 1, synchronous flush of in-flight word and counter.
REQ-007 SHALL have port cfg_size_i, input, 2, bytes per word: 00=1, 01=2, 10=4, 11=4.
REQ-008 SHALL have port cfg_msb_first_i, input, 1, 0=byte 0 (bits 7:0) first, 1=most significant valid byte first.
REQ-009 SHALL have port data_i, input, DATA_WIDTH, word from upstream TX FIFO.
REQ-010 SHALL have ports sof_i and eof_i, input, 1 each, frame marks attached to data_i.
REQ-011 SHALL have ports valid_i (input, 1) and ready_o (output, 1), upstream handshake.
REQ-012 SHALL have port data_o, output, OUT_WIDTH, serialized byte.
REQ-013 SHALL have ports sof_o and eof_o, output, 1 each, byte-level frame marks.
REQ-014 SHALL have ports valid_o (output, 1) and ready_i (input, 1), downstream handshake.
REQ-015 SHALL have port busy_o, output, 1, high while a word is held.
REQ-016 SHALL have port tx_bytes_o, output, 16, count of bytes handed off since reset/clr.

Function
REQ-017 SHALL be in one of two states, IDLE (no word held) and SHIFT (word held, valid_o=1).
REQ-018 A transfer on either side SHALL occur only on a cycle with valid & ready both high.
REQ-019 ready_o SHALL be high in IDLE, and in SHIFT only when the last byte is handed off that cycle (r_remain==1 & ready_i), giving zero-bubble back-to-back words.
REQ-020 On a word accept, the word, sof_i, eof_i, decoded size and cfg_msb_first_i SHALL be latched, and the block SHALL enter or stay in SHIFT with valid_o=1 the next cycle (latency 1).
REQ-021 Changes of cfg_size_i or cfg_msb_first_i SHALL NOT affect a word already latched.
REQ-022 With LSB-first, byte k (k=0..size-1) SHALL be data_i[8k+7:8k]; with MSB-first, bytes SHALL go out in order size-1 down to 0; bytes at or above size SHALL be discarded.
REQ-023 A 3-bit remaining-byte counter SHALL load size on accept and decrement on each output handshake; on reaching 0 with no new accept, the block SHALL return to IDLE.
REQ-024 sof_o SHALL be high only on the first byte of a word latched with sof=1; eof_o SHALL be high only on the last byte of a word latched with eof=1; both SHALL be high on a size-1 word with both marks set.
REQ-025 data_o, sof_o and eof_o SHALL hold stable while valid_o=1 and ready_i=0.
REQ-026 tx_bytes_o SHALL increment by 1 per output handshake and saturate at 0xFFFF.
REQ-027 busy_o SHALL equal valid_o.
REQ-028 clr_i SHALL force IDLE, valid_o=0 and tx_bytes_o=0 the next cycle, discarding any held word; ready_o SHALL be 0 during the clr_i cycle, and no upstream accept SHALL occur on it.
REQ-029 If clr_i and rst_i are asserted together, rst_i SHALL take precedence; the results are identical.

Reset
REQ-030 While rst_i=1, the block SHALL hold ready_o=0; on the cycle after rst_i is released, the block SHALL be in IDLE with ready_o=1.
REQ-031 After rst_i, the block SHALL be in IDLE with valid_o=0, data_o=0x00, sof_o=0, eof_o=0, busy_o=0, tx_bytes_o=0 and counter=0.
REQ-032 Assertion of rst_i mid-word SHALL drop the word with no further output bytes.

Verification
REQ-033 A bench SHALL check: size=4, LSB-first, ready_i=1, word 0x44332211 with sof=1, eof=1 -> bytes 11,22,33,44 on 4 consecutive cycles, sof_o on 0x11 only, eof_o on 0x44 only, tx_bytes_o=4.
REQ-034 A bench SHALL check: size=2, MSB-first, two back-to-back words 0xAABB1234, 0xCCDD5678 -> 12,34,56,78 with no idle cycle, ready_o pulsing on the cycles 0x34 and 0x78 are sent.
REQ-035 A bench SHALL check: downstream stall, ready_i=0 for 5 cycles during byte 1 -> data_o stable at that byte, ready_o=0, tx_bytes_o unchanged.
REQ-036 A bench SHALL check: cfg_size_i changed from 10 to 00 mid-word -> current word completes 4 bytes and the next word emits 1 byte.
REQ-037 A bench SHALL check: clr_i after 2 of 4 bytes -> valid_o=0 next cycle, tx_bytes_o=0, and the next accepted word starts at byte 0.
REQ-038 A bench SHALL check: 65540 single-byte words -> tx_bytes_o saturates at 0xFFFF.
